// File: rtl/hazard_ctrl.sv
// Load-use / dmem-wait / redirect hazard controller for the five-stage RV32I pipe.
// Stage enables are combinational from the inputs; only the stale-fetch flag and the perf counters are state.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_s,
    input  logic [4:0]       id_rs2_s,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd_s,
    input  logic             ex_redirect,
    input  logic             imem_resp,
    input  logic             mem_req,
    input  logic             dmem_resp,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        R_RESET,
        R_DSTALL,
        R_REDIR,
        R_STALE,
        R_LDUSE,
        R_NOFETCH,
        R_RUN
    } rule_t;

    rule_t rule;
    logic  drop_pending;
    logic  drop_next;
    logic  dmem_stall;
    logic  rs1_hit;
    logic  rs2_hit;
    logic  load_use;

    assign dmem_stall = mem_req & ~dmem_resp;
    assign rs1_hit    = id_uses_rs1 & (id_rs1_s == ex_rd_s);
    assign rs2_hit    = id_uses_rs2 & (id_rs2_s == ex_rd_s);
    // x0 is never a real producer, so a load to x0 can't create a hazard.
    assign load_use   = ex_valid & ex_is_load & (ex_rd_s != 5'd0) & id_valid
                      & (rs1_hit | rs2_hit);

    always_comb begin
        rule = R_RUN;
        if (!rst)
            rule = R_RESET;
        else if (dmem_stall)
            rule = R_DSTALL;
        else if (ex_redirect)
            rule = R_REDIR;
        else if (drop_pending && imem_resp)
            rule = R_STALE;
        else if (load_use)
            rule = R_LDUSE;
        else if (!imem_resp)
            rule = R_NOFETCH;
    end

    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_we    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        drop_next    = drop_pending;
        case (rule)
            R_RESET, R_DSTALL: begin
                // Whole pipe frozen; any redirect or hazard re-presents next cycle.
            end
            R_REDIR: begin
                pc_we        = 1'b1;
                if_id_we     = 1'b1;
                id_ex_we     = 1'b1;
                ex_mem_we    = 1'b1;
                mem_wb_we    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                // A fetch still outstanding belongs to the wrong path.
                drop_next    = ~imem_resp;
            end
            R_STALE: begin
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
                if_id_flush = 1'b1;
                drop_next   = 1'b0;
            end
            R_LDUSE: begin
                id_ex_we     = 1'b1;
                ex_mem_we    = 1'b1;
                mem_wb_we    = 1'b1;
                id_ex_bubble = 1'b1;
            end
            R_NOFETCH: begin
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
                if_id_flush = 1'b1;
            end
            default: begin
                pc_we     = 1'b1;
                if_id_we  = 1'b1;
                id_ex_we  = 1'b1;
                ex_mem_we = 1'b1;
                mem_wb_we = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_pending <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            drop_pending <= drop_next;
            if (!pc_we && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + CNT_ONE;
            if (rule == R_REDIR && flush_count != CNT_MAX)
                flush_count <= flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; ctl packs {pc,if_id,id_ex,ex_mem,mem_wb we, if_id_flush, id_ex_bubble}.
module tb_hazard_ctrl;
    logic       clk;
    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0] id_rs1_s, id_rs2_s, ex_rd_s;
    logic       ex_valid, ex_is_load, ex_redirect, imem_resp, mem_req, dmem_resp;
    logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble;
    logic [3:0] stall_cycles, flush_count;
    logic [6:0] ctl;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] C_RUN   = 7'b1111100;
    localparam logic [6:0] C_ZERO  = 7'b0000000;
    localparam logic [6:0] C_REDIR = 7'b1111111;
    localparam logic [6:0] C_LDUSE = 7'b0011101;
    localparam logic [6:0] C_FLUSH = 7'b0111110;

    hazard_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_s(id_rs1_s), .id_rs2_s(id_rs2_s),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd_s(ex_rd_s),
        .ex_redirect(ex_redirect), .imem_resp(imem_resp),
        .mem_req(mem_req), .dmem_resp(dmem_resp),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_valid = 1'b1; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_rs1_s = 5'd0; id_rs2_s = 5'd0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd_s = 5'd0;
        ex_redirect = 1'b0; imem_resp = 1'b1; mem_req = 1'b0; dmem_resp = 1'b0;
    endtask

    // lw x5 in EX, add reading x5 through rs1 in ID
    task automatic load_use_rs1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_s = 5'd5;
        id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1_s = 5'd5;
    endtask

    initial begin
        idle();
        imem_resp = 1'b0;
        rst = 1'b0;
        #1;
        chk("reset_ctl", {9'd0, ctl}, {9'd0, C_ZERO});
        repeat (2) tick();
        chk("reset_stall_cnt", {12'd0, stall_cycles}, 16'd0);
        chk("reset_flush_cnt", {12'd0, flush_count}, 16'd0);

        rst = 1'b1;
        idle();
        #1 chk("run_ctl", {9'd0, ctl}, {9'd0, C_RUN});
        tick();
        chk("run_no_stall", {12'd0, stall_cycles}, 16'd0);

        load_use_rs1();
        #1 chk("ldu_rs1_ctl", {9'd0, ctl}, {9'd0, C_LDUSE});
        tick();
        ex_valid = 1'b0;
        #1 chk("ldu_next_ctl", {9'd0, ctl}, {9'd0, C_RUN});
        chk("ldu_stall_cnt", {12'd0, stall_cycles}, 16'd1);
        tick();

        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_s = 5'd0;
        id_uses_rs1 = 1'b1; id_rs1_s = 5'd0;
        #1 chk("rd0_no_hazard", {9'd0, ctl}, {9'd0, C_RUN});
        ex_rd_s = 5'd5; id_rs1_s = 5'd3; id_rs2_s = 5'd5; id_uses_rs2 = 1'b0;
        #1 chk("rs2_unused_no_hazard", {9'd0, ctl}, {9'd0, C_RUN});
        id_uses_rs2 = 1'b1;
        #1 chk("ldu_rs2_ctl", {9'd0, ctl}, {9'd0, C_LDUSE});
        id_valid = 1'b0;
        #1 chk("id_invalid_no_hazard", {9'd0, ctl}, {9'd0, C_RUN});
        id_valid = 1'b1; ex_is_load = 1'b0;
        #1 chk("not_load_no_hazard", {9'd0, ctl}, {9'd0, C_RUN});
        idle();
        tick();

        mem_req = 1'b1; dmem_resp = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("dmem_freeze_ctl", {9'd0, ctl}, {9'd0, C_ZERO});
            tick();
        end
        chk("dmem_freeze_flush_cnt", {12'd0, flush_count}, 16'd0);
        chk("dmem_freeze_stall_cnt", {12'd0, stall_cycles}, 16'd4);
        dmem_resp = 1'b1;
        #1 chk("dmem_release_redir", {9'd0, ctl}, {9'd0, C_REDIR});
        tick();
        chk("dmem_release_flush_cnt", {12'd0, flush_count}, 16'd1);
        idle();

        // redirect with a pending fetch, also outranking a load-use
        ex_redirect = 1'b1; imem_resp = 1'b0; load_use_rs1();
        #1 chk("stale_redir_ctl", {9'd0, ctl}, {9'd0, C_REDIR});
        tick();
        idle(); imem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("stale_wait_ctl", {9'd0, ctl}, {9'd0, C_FLUSH});
            tick();
        end
        imem_resp = 1'b1; load_use_rs1();
        #1 chk("stale_drop_ctl", {9'd0, ctl}, {9'd0, C_FLUSH});
        tick();
        idle();
        #1 chk("stale_after_ctl", {9'd0, ctl}, {9'd0, C_RUN});
        tick();
        chk("stale_stall_cnt", {12'd0, stall_cycles}, 16'd7);
        chk("stale_flush_cnt", {12'd0, flush_count}, 16'd2);

        ex_redirect = 1'b1; imem_resp = 1'b0;
        tick();
        imem_resp = 1'b1;
        #1 chk("redir_over_drop_ctl", {9'd0, ctl}, {9'd0, C_REDIR});
        tick();
        idle();
        #1 chk("redir_over_drop_cleared", {9'd0, ctl}, {9'd0, C_RUN});
        tick();
        chk("redir2_flush_cnt", {12'd0, flush_count}, 16'd4);

        load_use_rs1(); mem_req = 1'b1; dmem_resp = 1'b0;
        #1 chk("ldu_dmem_hold", {9'd0, ctl}, {9'd0, C_ZERO});
        tick();
        dmem_resp = 1'b1;
        #1 chk("ldu_after_dmem", {9'd0, ctl}, {9'd0, C_LDUSE});
        tick();
        idle();
        #1 chk("ldu_dmem_stall_cnt", {12'd0, stall_cycles}, 16'd9);

        imem_resp = 1'b0;
        repeat (6) tick();
        chk("stall_reach_max", {12'd0, stall_cycles}, 16'd15);
        repeat (14) tick();
        chk("stall_saturate", {12'd0, stall_cycles}, 16'd15);

        idle(); ex_redirect = 1'b1;
        repeat (11) tick();
        chk("flush_reach_max", {12'd0, flush_count}, 16'd15);
        tick();
        chk("flush_saturate", {12'd0, flush_count}, 16'd15);

        // set drop_pending, then sit in a load-use stall and pull reset mid-cycle
        imem_resp = 1'b0;
        tick();
        ex_redirect = 1'b0; load_use_rs1();
        #1 chk("pre_reset_ldu", {9'd0, ctl}, {9'd0, C_LDUSE});
        #1 rst = 1'b0;
        #1 chk("async_reset_ctl", {9'd0, ctl}, {9'd0, C_ZERO});
        chk("async_reset_stall_cnt", {12'd0, stall_cycles}, 16'd0);
        chk("async_reset_flush_cnt", {12'd0, flush_count}, 16'd0);
        tick();
        chk("reset_hold_stall_cnt", {12'd0, stall_cycles}, 16'd0);
        rst = 1'b1;
        idle();
        #1 chk("no_drop_after_reset", {9'd0, ctl}, {9'd0, C_RUN});
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
